// File: rtl/video_timing_gen.sv
// Pixel-clock raster generator: drives cx/cy upstream and re-aligns the
// returned rgb with de/hsync/vsync for the video PHY.
module video_timing_gen #(
    parameter int FRAME_WIDTH   = 2200,
    parameter int FRAME_HEIGHT  = 1125,
    parameter int SCREEN_WIDTH  = 1920,
    parameter int SCREEN_HEIGHT = 1080,
    parameter int HSYNC_START   = 2008,
    parameter int HSYNC_END     = 2052,
    parameter int VSYNC_START   = 1084,
    parameter int VSYNC_END     = 1089,
    parameter bit HSYNC_POL     = 1'b1,
    parameter bit VSYNC_POL     = 1'b1,
    parameter int BIT_WIDTH     = 12,
    parameter int BIT_HEIGHT    = 11,
    parameter int RGB_LATENCY   = 2
) (
    input  logic                  clk_pixel,
    input  logic                  reset,
    input  logic                  enable,
    output logic [BIT_WIDTH-1:0]  cx,
    output logic [BIT_HEIGHT-1:0] cy,
    output logic                  frame_start,
    input  logic [23:0]           rgb_in,
    output logic                  vid_de,
    output logic                  vid_hsync,
    output logic                  vid_vsync,
    output logic [23:0]           vid_rgb,
    output logic [31:0]           frame_count
);

    localparam logic [BIT_WIDTH-1:0]  CX_LAST = BIT_WIDTH'(FRAME_WIDTH - 1);
    localparam logic [BIT_HEIGHT-1:0] CY_LAST = BIT_HEIGHT'(FRAME_HEIGHT - 1);
    localparam logic [BIT_WIDTH-1:0]  SW      = BIT_WIDTH'(SCREEN_WIDTH);
    localparam logic [BIT_HEIGHT-1:0] SH      = BIT_HEIGHT'(SCREEN_HEIGHT);
    localparam logic [BIT_WIDTH-1:0]  HS_S    = BIT_WIDTH'(HSYNC_START);
    localparam logic [BIT_WIDTH-1:0]  HS_E    = BIT_WIDTH'(HSYNC_END);
    localparam logic [BIT_HEIGHT-1:0] VS_S    = BIT_HEIGHT'(VSYNC_START);
    localparam logic [BIT_HEIGHT-1:0] VS_E    = BIT_HEIGHT'(VSYNC_END);
    localparam int                    L       = RGB_LATENCY;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [BIT_WIDTH-1:0]  cx_q, cx_d;
    logic [BIT_HEIGHT-1:0] cy_q, cy_d;
    logic                  fs_q, fs_d;
    logic [31:0]           fc_q;

    logic                  de_raw, hs_raw, vs_raw, run;
    logic [L-1:0]          de_sr_q, de_sr_d;
    logic [L-1:0]          hs_sr_q, hs_sr_d;
    logic [L-1:0]          vs_sr_q, vs_sr_d;

    logic                  de_q, hs_q, vs_q;
    logic [23:0]           rgb_q;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        fs_d    = 1'b0;
        case (state_q)
            IDLE: begin
                cx_d = '0;
                cy_d = '0;
                if (enable) begin
                    state_d = RUN;
                    fs_d    = 1'b1;
                end
            end
            RUN: begin
                if (cx_q == CX_LAST) begin
                    cx_d = '0;
                    if (cy_q == CY_LAST) begin
                        // enable only matters at the frame boundary
                        cy_d = '0;
                        if (enable) begin
                            fs_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cy_d = cy_q + 1'b1;
                    end
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cx_d    = '0;
                cy_d    = '0;
            end
        endcase
    end

    assign run    = (state_q == RUN);
    assign de_raw = run && (cx_q < SW) && (cy_q < SH);
    assign hs_raw = (run && (cx_q >= HS_S) && (cx_q < HS_E))
                    ? HSYNC_POL : ~HSYNC_POL;
    assign vs_raw = (run && (cy_q >= VS_S) && (cy_q < VS_E))
                    ? VSYNC_POL : ~VSYNC_POL;

    assign de_sr_d = L'({de_sr_q, de_raw});
    assign hs_sr_d = L'({hs_sr_q, hs_raw});
    assign vs_sr_d = L'({vs_sr_q, vs_raw});

    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            fs_q    <= 1'b0;
            fc_q    <= '0;
            de_sr_q <= '0;
            hs_sr_q <= {L{~HSYNC_POL}};
            vs_sr_q <= {L{~VSYNC_POL}};
            de_q    <= 1'b0;
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            rgb_q   <= '0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            fs_q    <= fs_d;
            if (fs_q) begin
                fc_q <= fc_q + 32'd1;
            end
            de_sr_q <= de_sr_d;
            hs_sr_q <= hs_sr_d;
            vs_sr_q <= vs_sr_d;
            de_q    <= de_sr_q[L-1];
            hs_q    <= hs_sr_q[L-1];
            vs_q    <= vs_sr_q[L-1];
            rgb_q   <= de_sr_q[L-1] ? rgb_in : 24'h0;
        end
    end

    assign cx          = cx_q;
    assign cy          = cy_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
    assign vid_de      = de_q;
    assign vid_hsync   = hs_q;
    assign vid_vsync   = vs_q;
    assign vid_rgb     = rgb_q;

endmodule
